// File: rtl/serial_adder.sv
// Bit-serial add/subtract, one bit per clock LSB first; done pulses WIDTH+1 edges after an accepted start.
// No backpressure: start is accepted only when idle or in the done cycle and is ignored while busy.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] shift;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             bit_s;
  logic             bit_c;

  assign bit_s = op_a[0] ^ op_b[0] ^ carry;
  assign bit_c = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      shift    <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // Subtraction is A + ~B + 1: invert B and force the initial carry.
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          shift <= {bit_s, shift[WIDTH-1:1]};
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          carry <= bit_c;
          if (cnt == LAST) begin
            // carry still holds the carry into the MSB on this edge.
            sum      <= {bit_s, shift[WIDTH-1:1]};
            cout     <= bit_c;
            overflow <= carry ^ bit_c;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Randomised self-checking bench for serial_adder at WIDTH=8 (directed/handshake) and WIDTH=16 (back-to-back stream).
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        s_start, s_cin, s_sub, s_busy, s_done, s_cout, s_ovf;
  logic [7:0]  s_a, s_b, s_sum;
  logic        w_start, w_cin, w_sub, w_busy, w_done, w_cout, w_ovf;
  logic [15:0] w_a, w_b, w_sum;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(s_start), .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub),
    .busy(s_busy), .done(s_done), .sum(s_sum), .cout(s_cout), .overflow(s_ovf)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(w_start), .a(w_a), .b(w_b), .cin(w_cin), .sub(w_sub),
    .busy(w_busy), .done(w_done), .sum(w_sum), .cout(w_cout), .overflow(w_ovf)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] last_sum;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic at width w; overflow from operand/result signs.
  function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                input logic ci, input logic sb,
                                output logic [63:0] s, output logic co, output logic ov);
    logic [63:0] mask, bb;
    logic [64:0] full;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    bb   = sb ? (~b & mask) : (b & mask);
    full = {1'b0, a & mask} + {1'b0, bb} + {64'd0, (sb ? 1'b1 : ci)};
    s    = full[63:0] & mask;
    co   = full[w];
    ov   = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
  endfunction

  task automatic check8_result(input string tag, input logic [7:0] a, input logic [7:0] b,
                               input logic ci, input logic sb);
    logic [63:0] es;
    logic eco, eov;
    model(8, {56'd0, a}, {56'd0, b}, ci, sb, es, eco, eov);
    check({tag, "_sum"}, 64'(s_sum), es);
    check({tag, "_cout"}, 64'(s_cout), 64'(eco));
    check({tag, "_ovf"}, 64'(s_ovf), 64'(eov));
    last_sum = s_sum;
  endtask

  // One full 8-bit operation with inputs scrambled and a stray start during RUN.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sb);
    logic [7:0] prev;
    prev = last_sum;
    s_a = a; s_b = b; s_cin = ci; s_sub = sb; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    check("busy_first", 64'(s_busy), 64'd1);
    for (int k = 1; k < 8; k++) begin
      s_a = 8'($urandom); s_b = 8'($urandom);
      s_cin = 1'($urandom); s_sub = 1'($urandom);
      s_start = (k == 3);
      tick();
      check("busy_run", 64'(s_busy), 64'd1);
      check("done_run", 64'(s_done), 64'd0);
      if (k == 4) check("sum_held", 64'(s_sum), 64'(prev));
    end
    s_start = 1'b0;
    tick();
    check("done_pulse", 64'(s_done), 64'd1);
    check("busy_end", 64'(s_busy), 64'd0);
    check8_result("r8", a, b, ci, sb);
    tick();
    check("done_one_cycle", 64'(s_done), 64'd0);
  endtask

  logic [63:0] q_sum[$];
  logic        q_co[$];
  logic        q_ov[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1);
  end

  initial begin
    int n, issued, recv, cyc;
    logic acc;
    logic [63:0] es;
    logic eco, eov;

    rst = 1'b1;
    s_start = 0; s_a = 0; s_b = 0; s_cin = 0; s_sub = 0;
    w_start = 0; w_a = 0; w_b = 0; w_cin = 0; w_sub = 0;
    last_sum = 8'd0;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", 64'(s_busy), 64'd0);
    check("rst_done", 64'(s_done), 64'd0);
    check("rst_sum", 64'(s_sum), 64'd0);
    check("rst_cout", 64'(s_cout), 64'd0);
    check("rst_ovf", 64'(s_ovf), 64'd0);
    check("rst_w_busy", 64'(w_busy), 64'd0);

    run8(8'h3C, 8'h5A, 1'b0, 1'b0);
    check("vec_3c5a", 64'(s_sum), 64'h96);
    run8(8'hFF, 8'h01, 1'b1, 1'b0);
    run8(8'h10, 8'h20, 1'b1, 1'b1);
    run8(8'h80, 8'h01, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

    // start held high through DONE: second op begins with no idle gap
    s_a = 8'h12; s_b = 8'h34; s_cin = 1'b1; s_sub = 1'b0; s_start = 1'b1;
    tick();
    s_a = 8'hC8; s_b = 8'h37; s_cin = 1'b0; s_sub = 1'b1;
    n = 0;
    while (!s_done && n < 20) begin tick(); n++; end
    check("b2b_first_lat", 64'(n), 64'd8);
    check8_result("b2b1", 8'h12, 8'h34, 1'b1, 1'b0);
    n = 0;
    do begin
      tick(); n++;
      if (n == 1) s_start = 1'b0;
    end while (!s_done && n < 20);
    check("b2b_gap", 64'(n), 64'd9);
    check8_result("b2b2", 8'hC8, 8'h37, 1'b0, 1'b1);
    tick();

    // reset mid-RUN after a known result
    run8(8'h3C, 8'h5A, 1'b0, 1'b0);
    s_a = 8'h11; s_b = 8'h22; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", 64'(s_busy), 64'd0);
    check("mid_rst_done", 64'(s_done), 64'd0);
    check("mid_rst_sum", 64'(s_sum), 64'd0);
    check("mid_rst_cout", 64'(s_cout), 64'd0);
    check("mid_rst_ovf", 64'(s_ovf), 64'd0);
    last_sum = 8'd0;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (s_done) n++;
    end
    check("no_done_after_rst", 64'(n), 64'd0);
    run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

    // WIDTH=16: 500 back-to-back random operations against the scoreboard
    w_start = 1'b1;
    w_a = 16'($urandom); w_b = 16'($urandom); w_cin = 1'($urandom); w_sub = 1'($urandom);
    issued = 0; recv = 0; cyc = 0;
    while (recv < 500 && cyc < 20000) begin
      acc = w_start && !w_busy;
      tick();
      cyc++;
      if (w_done) begin
        if (q_sum.size() == 0) begin
          check("w_spurious_done", 64'd1, 64'd0);
        end else begin
          check("w_sum", {47'd0, w_cout, w_sum}, {47'd0, q_co.pop_front(), q_sum.pop_front()[15:0]});
          check("w_ovf", 64'(w_ovf), 64'(q_ov.pop_front()));
        end
        recv++;
      end
      if (acc) begin
        model(16, {48'd0, w_a}, {48'd0, w_b}, w_cin, w_sub, es, eco, eov);
        q_sum.push_back(es); q_co.push_back(eco); q_ov.push_back(eov);
        issued++;
        if (issued == 500) begin
          w_start = 1'b0;
        end else begin
          w_a = 16'($urandom); w_b = 16'($urandom);
          w_cin = 1'($urandom); w_sub = 1'($urandom);
        end
      end
    end
    check("w_count", 64'(recv), 64'd500);
    check("w_cycles", 64'(cyc), 64'd8500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
